// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter:
//   - receiver FSM state encoding
//   - frame data width
//   - default clock and baud settings
//   - helper that derives the oversample tick divider
// No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_CLK_FREQ   = 50_000_000;
  localparam int DEFAULT_BAUD_RATE  = 115_200;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rxState_e;

  // System clocks per oversample tick. The caller must keep the result >= 1.
  function automatic int calcTickDiv(input int clkFreq, input int baudRate,
                                     input int oversample);
    return clkFreq / (baudRate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider that emits one oversample tick every TICK_DIV clocks.
// A restart pulse puts the count back at zero, so the tick phase can be lined
// up with an incoming frame.
// Ports:
//   clk_i      in  system clock, rising edge
//   rst_ni     in  asynchronous active-low reset
//   restart_i  in  restart the count from 0 on the next clock
//   tick_o     out high while the count sits at its terminal value
// ----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(TICK_DIV - 1) + 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..TICK_DIV-1 and wrap. A restart wins over the normal count.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver: 8N1 frames, LSB first. It oversamples the
// line, checks the start bit and decides each bit by a 2-of-3 vote around mid
// bit. Each received byte is offered on a valid/ack handshake.
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   rx_serial     in   serial line (asynchronous to clk, idles high)
//   rx_ack        in   consumer accepts rx_data; clears rx_valid/rx_overrun
//   rx_data       out  last correctly framed byte
//   rx_valid      out  high from byte completion until rx_ack
//   rx_frame_err  out  one-cycle pulse when the stop bit is sampled low
//   rx_overrun    out  sticky: a byte completed while rx_valid was still high
//   rx_busy       out  high from accepted start edge until back in IDLE
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int TICK_DIV = calcTickDiv(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE - 1) + 1;

  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] MID_M1    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] MID       = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] MID_P1    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic rxMeta_q, rxSync_q, rxPrev_q;

  rxState_e       state_q, state_d;
  logic [SW-1:0]  sampCnt_q, sampCnt_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [7:0]     shift_q, shift_d;
  logic           early0_q, early0_d;
  logic           early1_q, early1_d;

  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           frameErr_q, frameErr_d;
  logic           overrun_q, overrun_d;

  logic tick;
  logic startEdge;
  logic vote;
  logic stopSample;
  logic goodByte;
  logic ackValid;

  // Two-flop synchronizer plus one history flop for edge detection. All reset
  // high so an idle line never looks like a falling edge out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_serial;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // A start needs a real 1->0 transition, so a held-low (break) line cannot
  // retrigger once the FSM is back in IDLE.
  assign startEdge = (state_q == IDLE) && rxPrev_q && !rxSync_q;

  uart_baud_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_baud_tick (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .restart_i (startEdge),
    .tick_o    (tick)
  );

  // Majority of the samples taken at mid-1, mid and the current one at mid+1.
  assign vote = (early0_q & early1_q) | (early0_q & rxSync_q) |
                (early1_q & rxSync_q);

  // Receiver FSM next state. The sample counter keeps running across bit
  // boundaries, so each decision point is simply the next mid+1 tick.
  always_comb begin
    state_d    = state_q;
    sampCnt_d  = sampCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    early0_d   = early0_q;
    early1_d   = early1_q;
    stopSample = 1'b0;

    case (state_q)
      IDLE: begin
        if (startEdge) begin
          state_d   = START;
          sampCnt_d = '0;
          bitIdx_d  = '0;
        end
      end
      default: begin
        if (tick) begin
          sampCnt_d = (sampCnt_q == SAMP_LAST) ? '0 : sampCnt_q + SW'(1);
          if (sampCnt_q == MID_M1) begin
            early0_d = rxSync_q;
          end
          if (sampCnt_q == MID) begin
            early1_d = rxSync_q;
          end
          if (sampCnt_q == MID_P1) begin
            case (state_q)
              START: begin
                // A high vote means the edge was a glitch, not a start bit.
                state_d = vote ? IDLE : DATA;
              end
              DATA: begin
                shift_d  = {vote, shift_q[7:1]};
                bitIdx_d = bitIdx_q + 3'd1;
                if (bitIdx_q == LAST_BIT) begin
                  state_d = STOP;
                end
              end
              STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen.
                stopSample = 1'b1;
                state_d    = IDLE;
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sampCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      early0_q  <= 1'b0;
      early1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sampCnt_q <= sampCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      early0_q  <= early0_d;
      early1_q  <= early1_d;
    end
  end

  assign goodByte = stopSample & vote;
  assign ackValid = rx_ack & valid_q;

  // Output handshake. Completion beats an ack in the same cycle, so the new
  // byte stays valid; an ack in that cycle also prevents the overrun flag.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    frameErr_d = stopSample & ~vote;

    if (ackValid) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (goodByte) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = frameErr_q;
  assign rx_overrun   = overrun_q;
  assign rx_busy      = (state_q != IDLE);

endmodule
